// File: rtl/vcgc_stream_checker.sv
// rtl/vcgc_stream_checker.sv - streaming graph vertex-colouring checker
// Conflict log (count + first bad edge) is built only when VCGC_CONFLICT_LOG_EN is defined.
module vcgc_stream_checker #(
   parameter int  N_VERT     = 37,
   parameter int  COLOR_W    = 2,
   parameter int  NUM_COLORS = 4,
   parameter int  CNT_W      = 16,
   localparam int AW         = (N_VERT > 1) ? $clog2(N_VERT) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               col_we_i,
   input  logic [AW-1:0]      col_addr_i,
   input  logic [COLOR_W-1:0] col_data_i,
   input  logic               start_i,
   input  logic               edge_valid_i,
   output logic               edge_ready_o,
   input  logic [AW-1:0]      edge_u_i,
   input  logic [AW-1:0]      edge_v_i,
   input  logic               edge_last_i,
   output logic               done_o,
   output logic               ok_o,
   output logic [CNT_W-1:0]   conflict_cnt_o,
   output logic [AW-1:0]      first_u_o,
   output logic [AW-1:0]      first_v_o
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DRAIN, S_DONE} state_t;

   localparam logic [AW:0]      NV_L = (AW+1)'(N_VERT);
   localparam logic [COLOR_W:0] NC_L = (COLOR_W+1)'(NUM_COLORS);

   state_t             state_q;
   logic [COLOR_W-1:0] color_q [N_VERT];
   logic               pipe_vld_q;
   logic [AW-1:0]      pipe_u_q;
   logic [AW-1:0]      pipe_v_q;
   logic               done_q;
   logic               ok_q;

   logic               idle_like;
   logic               accept;
   logic               start_ok;
   logic               u_oor;
   logic               v_oor;
   logic [COLOR_W-1:0] col_u;
   logic [COLOR_W-1:0] col_v;
   logic               bad;

   assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept       = edge_valid_i && (state_q == S_CHECK);
   assign start_ok     = start_i && idle_like;
   assign edge_ready_o = (state_q == S_CHECK);
   assign done_o       = done_q;
   assign ok_o         = ok_q;

   // Colour file is deliberately outside reset so colours survive an aborted pass.
   always_ff @(posedge clk_i) begin
      if (col_we_i && idle_like && ({1'b0, col_addr_i} < NV_L)) begin
         color_q[col_addr_i] <= col_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         pipe_u_q <= edge_u_i;
         pipe_v_q <= edge_v_i;
      end
   end

   always_comb begin
      u_oor = ({1'b0, pipe_u_q} >= NV_L);
      v_oor = ({1'b0, pipe_v_q} >= NV_L);
      col_u = '0;
      col_v = '0;
      if (!u_oor) col_u = color_q[pipe_u_q];
      if (!v_oor) col_v = color_q[pipe_v_q];
      bad = pipe_vld_q && (u_oor || v_oor || (col_u == col_v) ||
                           ({1'b0, col_u} >= NC_L) || ({1'b0, col_v} >= NC_L));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         pipe_vld_q <= 1'b0;
      end else begin
         pipe_vld_q <= accept;
         if (bad) ok_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q <= S_CHECK;
                  ok_q    <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            S_CHECK: begin
               if (accept && edge_last_i) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef VCGC_CONFLICT_LOG_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [AW-1:0]    first_u_q;
   logic [AW-1:0]    first_v_q;

   assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // ok_q is still 1 while the first bad edge of a pass is evaluated.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_ok) begin
         cnt_q     <= '0;
         first_u_q <= '0;
         first_v_q <= '0;
      end else if (bad) begin
         cnt_q <= cnt_d;
         if (ok_q) begin
            first_u_q <= pipe_u_q;
            first_v_q <= pipe_v_q;
         end
      end
   end

   assign conflict_cnt_o = cnt_q;
   assign first_u_o      = first_u_q;
   assign first_v_o      = first_v_q;
`else
   assign conflict_cnt_o = '0;
   assign first_u_o      = '0;
   assign first_v_o      = '0;
`endif

endmodule

// File: tb/tb_vcgc_stream_checker.sv
// tb/tb_vcgc_stream_checker.sv - scoreboard bench for vcgc_stream_checker
// Three instances share stimulus: default, NUM_COLORS=3, CNT_W=2.
module tb_vcgc_stream_checker;

   localparam int NV = 37;
   localparam int AW = 6;
`ifdef VCGC_CONFLICT_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]       ok;
      logic [2:0][15:0] cnt;
      logic [2:0][5:0]  fu;
      logic [2:0][5:0]  fv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic col_we = 1'b0;
   logic [AW-1:0] col_addr = '0;
   logic [1:0] col_data = '0;
   logic start = 1'b0;
   logic ev = 1'b0;
   logic el = 1'b0;
   logic [AW-1:0] eu = '0;
   logic [AW-1:0] evv = '0;

   logic [2:0] rdy_w, done_w, ok_w;
   logic [15:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic [2:0][AW-1:0] fu_w, fv_w;

   int n_tests = 0;
   int n_fail = 0;

   logic [1:0] mcol [64];
   bit mok [3];
   int mcnt [3];
   int mfu [3];
   int mfv [3];
   exp_t sbq [$];
   exp_t last_e;

   always #5 clk = ~clk;

   vcgc_stream_checker #(.N_VERT(NV), .COLOR_W(2), .NUM_COLORS(4), .CNT_W(16)) dut_a (
      .clk_i(clk), .rst_i(rst), .col_we_i(col_we), .col_addr_i(col_addr), .col_data_i(col_data),
      .start_i(start), .edge_valid_i(ev), .edge_ready_o(rdy_w[0]), .edge_u_i(eu), .edge_v_i(evv),
      .edge_last_i(el), .done_o(done_w[0]), .ok_o(ok_w[0]), .conflict_cnt_o(cnt_a),
      .first_u_o(fu_w[0]), .first_v_o(fv_w[0]));

   vcgc_stream_checker #(.N_VERT(NV), .COLOR_W(2), .NUM_COLORS(3), .CNT_W(16)) dut_b (
      .clk_i(clk), .rst_i(rst), .col_we_i(col_we), .col_addr_i(col_addr), .col_data_i(col_data),
      .start_i(start), .edge_valid_i(ev), .edge_ready_o(rdy_w[1]), .edge_u_i(eu), .edge_v_i(evv),
      .edge_last_i(el), .done_o(done_w[1]), .ok_o(ok_w[1]), .conflict_cnt_o(cnt_b),
      .first_u_o(fu_w[1]), .first_v_o(fv_w[1]));

   vcgc_stream_checker #(.N_VERT(NV), .COLOR_W(2), .NUM_COLORS(4), .CNT_W(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .col_we_i(col_we), .col_addr_i(col_addr), .col_data_i(col_data),
      .start_i(start), .edge_valid_i(ev), .edge_ready_o(rdy_w[2]), .edge_u_i(eu), .edge_v_i(evv),
      .edge_last_i(el), .done_o(done_w[2]), .ok_o(ok_w[2]), .conflict_cnt_o(cnt_c),
      .first_u_o(fu_w[2]), .first_v_o(fv_w[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_cnt(input int k);
      case (k)
         0:       return 32'(cnt_a);
         1:       return 32'(cnt_b);
         default: return 32'(cnt_c);
      endcase
   endfunction

   task automatic write_col(input int addr, input int data);
      col_we = 1'b1;
      col_addr = AW'(addr);
      col_data = 2'(data);
      tick();
      col_we = 1'b0;
      if (addr < NV) mcol[addr] = 2'(data);
   endtask

   task automatic model_edge(input int u, input int v);
      for (int k = 0; k < 3; k++) begin
         int nc, mx, cu, cv;
         bit b;
         nc = (k == 1) ? 3 : 4;
         mx = (k == 2) ? 3 : 65535;
         cu = (u < NV) ? int'(mcol[u]) : 0;
         cv = (v < NV) ? int'(mcol[v]) : 0;
         b = (u >= NV) || (v >= NV) || (cu == cv) || (cu >= nc) || (cv >= nc);
         if (b) begin
            if (LOG) begin
               if (mok[k]) begin
                  mfu[k] = u;
                  mfv[k] = v;
               end
               if (mcnt[k] < mx) mcnt[k]++;
            end
            mok[k] = 1'b0;
         end
      end
   endtask

   task automatic begin_pass();
      for (int k = 0; k < 3; k++) begin
         mok[k] = 1'b1;
         mcnt[k] = 0;
         mfu[k] = 0;
         mfv[k] = 0;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ready_in_check", 32'(rdy_w), 32'b111);
      check("done_clear_on_start", 32'(done_w), 32'b000);
   endtask

   task automatic drive_edge(input int u, input int v, input bit last);
      eu = AW'(u);
      evv = AW'(v);
      el = last;
      ev = 1'b1;
      tick();
      model_edge(u, v);
   endtask

   task automatic compare(input exp_t e, input string ph);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s done[%0d]", ph, k), 32'(done_w[k]), 32'd1);
         check($sformatf("%s ok[%0d]", ph, k), 32'(ok_w[k]), 32'(e.ok[k]));
         check($sformatf("%s cnt[%0d]", ph, k), get_cnt(k), 32'(e.cnt[k]));
         check($sformatf("%s first_u[%0d]", ph, k), 32'(fu_w[k]), 32'(e.fu[k]));
         check($sformatf("%s first_v[%0d]", ph, k), 32'(fv_w[k]), 32'(e.fv[k]));
      end
   endtask

   task automatic end_pass(input string ph);
      exp_t e;
      int lat;
      ev = 1'b0;
      el = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e.ok[k] = mok[k];
         e.cnt[k] = 16'(mcnt[k]);
         e.fu[k] = 6'(mfu[k]);
         e.fv[k] = 6'(mfv[k]);
      end
      sbq.push_back(e);
      lat = 0;
      while (done_w[0] !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      // Counted from the acceptance cycle, so the accepting edge itself is cycle 1.
      check({ph, " done_latency"}, 32'(lat + 1), 32'd2);
      last_e = sbq.pop_front();
      compare(last_e, ph);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mcol[i] = 2'd0;
      tick();
      tick();
      rst = 1'b0;
      check("rst done", 32'(done_w), 32'b000);
      check("rst ok", 32'(ok_w), 32'b000);
      check("rst ready", 32'(rdy_w), 32'b000);
      for (int k = 0; k < 3; k++) check($sformatf("rst cnt[%0d]", k), get_cnt(k), 32'd0);

      for (int i = 0; i < NV; i++) write_col(i, i % 4);
      write_col(40, 1);

      begin_pass();
      drive_edge(0, 1, 1'b0);
      drive_edge(1, 2, 1'b0);
      drive_edge(2, 3, 1'b1);
      end_pass("proper");

      write_col(5, 2);
      write_col(9, 2);
      begin_pass();
      start = 1'b1;
      col_we = 1'b1;
      col_addr = 6'd0;
      col_data = 2'd1;
      drive_edge(0, 1, 1'b0);
      start = 1'b0;
      col_we = 1'b0;
      drive_edge(5, 9, 1'b0);
      drive_edge(9, 5, 1'b1);
      end_pass("conflict");
      repeat (3) tick();
      compare(last_e, "hold");

      write_col(4, 3);
      begin_pass();
      drive_edge(4, 0, 1'b0);
      drive_edge(40, 1, 1'b1);
      end_pass("illegal");

      begin_pass();
      for (int i = 0; i < 5; i++) drive_edge(3, 3, i == 4);
      end_pass("saturate");

      begin_pass();
      drive_edge(0, 1, 1'b0);
      drive_edge(5, 9, 1'b0);
      eu = 6'd9;
      evv = 6'd5;
      el = 1'b1;
      ev = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ev = 1'b0;
      el = 1'b0;
      repeat (3) tick();
      check("midrst done", 32'(done_w), 32'b000);
      check("midrst ok", 32'(ok_w), 32'b000);
      check("midrst ready", 32'(rdy_w), 32'b000);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("midrst cnt[%0d]", k), get_cnt(k), 32'd0);
         check($sformatf("midrst first_u[%0d]", k), 32'(fu_w[k]), 32'd0);
      end

      begin_pass();
      drive_edge(0, 1, 1'b0);
      drive_edge(5, 9, 1'b0);
      drive_edge(9, 5, 1'b1);
      end_pass("after_rst");

      begin_pass();
      drive_edge(0, 1, 1'b0);
      drive_edge(1, 2, 1'b0);
      drive_edge(2, 3, 1'b1);
      end_pass("retained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vcgc_stream_checker.md
VCGC_STREAM_CHECKER -- requirements
Module: vcgc_stream_checker

Interface
REQ-001 Parameter N_VERT, default 37: number of graph vertices.
REQ-002 Parameter COLOR_W, default 2: colour width in bits.
REQ-003 Parameter NUM_COLORS, default 4: legal colours are 0..NUM_COLORS-1, with NUM_COLORS <= 2^COLOR_W.
REQ-004 Parameter CNT_W, default 16: conflict counter width.
REQ-005 Derived AW = clog2(N_VERT), minimum 1.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 col_we  in  1  colour write strobe.
REQ-009 col_addr  in  AW  vertex index for the colour write.
REQ-010 col_data  in  COLOR_W  colour value for the colour write.
REQ-011 start  in  1  begin a check pass.
REQ-012 edge_valid  in  1  edge offered.
REQ-013 edge_ready  out  1  edge accepted when edge_valid and edge_ready are both high.
REQ-014 edge_u, edge_v  in  AW each  edge endpoints.
REQ-015 edge_last  in  1  marks the final edge of the pass.
REQ-016 done  out  1  result valid.
REQ-017 ok  out  1  colouring proper and legal.
REQ-018 conflict_cnt  out  CNT_W  number of bad edges.
REQ-019 first_u, first_v  out  AW each  endpoints of the first bad edge.

Function
REQ-020 The block SHALL hold an N_VERT x COLOR_W colour register file, written on col_we only in IDLE or DONE; writes in CHECK or DRAIN are ignored; writes with col_addr >= N_VERT are ignored.
REQ-021 The FSM SHALL have the states IDLE, CHECK, DRAIN and DONE.
REQ-022 IDLE or DONE with start=1 SHALL go to CHECK and clear ok to 1, conflict_cnt to 0, first_u/first_v to 0 and done to 0.
REQ-023 edge_ready SHALL be 1 only in CHECK.
REQ-024 An accepted edge SHALL be registered into a 1-stage compare pipeline and evaluated on the next cycle.
REQ-025 An evaluated edge is bad if any of the following holds: edge_u >= N_VERT; edge_v >= N_VERT; colour(u) == colour(v); colour(u) >= NUM_COLORS; colour(v) >= NUM_COLORS.
REQ-026 A self-loop (u==v) with a legal colour SHALL count as bad.
REQ-027 On a bad edge the block SHALL clear ok to 0 and increment conflict_cnt, saturating at 2^CNT_W-1.
REQ-028 A bad edge SHALL load first_u/first_v only if it is the first bad edge of the pass.
REQ-029 An accepted edge with edge_last=1 SHALL move the FSM CHECK -> DRAIN; DRAIN lasts exactly 1 cycle and then goes to DONE.
REQ-030 done SHALL be 1 from the cycle after DRAIN, so the last edge shows in the results 2 cycles after its acceptance.
REQ-031 DONE SHALL hold done=1 and all results stable until the next start.
REQ-032 A start received in CHECK or DRAIN SHALL be ignored.
REQ-033 A pass with zero edges is impossible (edge_last is required); ok stays 1 until an edge is evaluated.
REQ-034 Throughput SHALL be 1 edge per cycle with no bubbles.

Reset
REQ-035 rst SHALL set: FSM=IDLE, done=0, ok=0, conflict_cnt=0, first_u=0, first_v=0, pipeline valid=0.
REQ-036 rst SHALL leave the colour register file unchanged.
REQ-037 rst asserted mid-CHECK SHALL abort the pass, discard the in-flight pipeline edge, and not assert done.

Configuration
REQ-038 The macro VCGC_CONFLICT_LOG_EN controls the conflict log.
REQ-039 With VCGC_CONFLICT_LOG_EN defined: conflict_cnt, first_u and first_v SHALL behave as in REQ-027 and REQ-028.
REQ-040 Without VCGC_CONFLICT_LOG_EN: conflict_cnt, first_u and first_v SHALL be tied to 0, no counter or capture registers SHALL be built, and ok/done SHALL be unchanged.

Verification
REQ-041 Proper colouring: N_VERT=37; load colour(i)=i mod 4; stream edges (0,1),(1,2),(2,3) with last on (2,3) -> done=1 two cycles after the last accept, ok=1, conflict_cnt=0.
REQ-042 Conflicts: colour(5)=colour(9)=2; stream (0,1),(5,9),(9,5) last -> ok=0, conflict_cnt=2, first_u=5, first_v=9.
REQ-043 Illegal colour and range: NUM_COLORS=3, colour(4)=3; stream (4,0) then (40,1) last -> conflict_cnt=2, first=(4,0).
REQ-044 Saturation: CNT_W=2; five self-loop edges -> conflict_cnt=3, ok=0.
REQ-045 Reset mid-pass: rst during the 3rd edge -> done=0, ok=0, conflict_cnt=0; colours are retained, and a new pass gives the same result as before the reset.
REQ-046 Macro off: rerun REQ-042 -> ok=0, conflict_cnt=0, first_u=0, first_v=0.
